// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg: widths, FSM state encoding and the byte-address to word-index helper
// shared by the SRAM controller and its wait counter.
package sram_controller_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int SRAM_DATA_WIDTH = 16;
  localparam int SRAM_ADDR_WIDTH = 18;
  localparam int INDEX_WIDTH = SRAM_ADDR_WIDTH - 1;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_t;
  // Byte offset from the mapped base, dropped to a 32-bit word index; address[1:0] fall away.
  function automatic logic [INDEX_WIDTH-1:0] word_index(input logic [WORD_WIDTH-1:0] addr,
                                                        input logic [WORD_WIDTH-1:0] base);
    return INDEX_WIDTH'((addr - base) >> 2);
  endfunction
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter that times each 16-bit half access;
// done is high on the last cycle of a phase.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam int CW = $clog2(WAIT_CYCLES) + 1;
  logic [CW-1:0] count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= '0;
    else if (load) count <= CW'(WAIT_CYCLES - 1);
    else if (en && count != '0) count <= count - 1'b1;
  end
  assign done = count == '0;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: 32-bit load/store port onto a 16-bit asynchronous SRAM, two halves per word.
// Define SRAM_READ_HIT_EN to add a one-entry buffer that answers repeated loads from IDLE.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [WORD_WIDTH-1:0]      address,
  input  logic [WORD_WIDTH-1:0]      write_data,
  output logic [WORD_WIDTH-1:0]      read_data,
  output logic                       ready,
  inout  wire  [SRAM_DATA_WIDTH-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic                       SRAM_WE_N,
  output logic                       SRAM_OE_N,
  output logic                       SRAM_CE_N,
  output logic                       SRAM_UB_N,
  output logic                       SRAM_LB_N
);
  state_t state, next_state;
  logic op_wr;
  logic [INDEX_WIDTH-1:0] idx, index_now;
  logic [WORD_WIDTH-1:0] wdata, rdata, hit_data;
  logic [SRAM_DATA_WIDTH-1:0] lo;
  logic req, hit, start, acc, cnt_done, load;
  assign index_now = word_index(address, WORD_WIDTH'(BASE_ADDR));
  assign req = rd_en | wr_en;
  assign start = state == IDLE && req && !hit;
  assign acc = state == ACC_LO || state == ACC_HI;
  assign load = start || (state == ACC_LO && cnt_done);
  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk (clk),
    .rst (rst),
    .load(load),
    .en  (acc),
    .done(cnt_done)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    ready = 1'b0;
    case (state)
      IDLE: begin
        ready = !req || hit;
        next_state = start ? ACC_LO : IDLE;
      end
      ACC_LO: next_state = cnt_done ? ACC_HI : ACC_LO;
      ACC_HI: next_state = cnt_done ? DONE : ACC_HI;
      default: begin
        ready = 1'b1;
        next_state = IDLE;
      end
    endcase
  end
  // Request fields are latched only when an access starts, so later changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr <= 1'b0;
      idx <= '0;
      wdata <= '0;
      lo <= '0;
      rdata <= '0;
    end else begin
      if (start) begin
        op_wr <= wr_en;
        idx <= index_now;
        wdata <= write_data;
      end
      if (hit) rdata <= hit_data;
      if (!op_wr && cnt_done && state == ACC_LO) lo <= SRAM_DQ;
      if (!op_wr && cnt_done && state == ACC_HI) rdata <= {SRAM_DQ, lo};
    end
  end
`ifdef SRAM_READ_HIT_EN
  logic buf_valid;
  logic [INDEX_WIDTH-1:0] buf_idx;
  logic [WORD_WIDTH-1:0] buf_data;
  assign hit = state == IDLE && rd_en && !wr_en && buf_valid && buf_idx == index_now;
  assign hit_data = buf_data;
  // Refilled by every completed read; a completed write to the same word keeps it coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_idx <= '0;
      buf_data <= '0;
    end else if (state == DONE && !op_wr) begin
      buf_valid <= 1'b1;
      buf_idx <= idx;
      buf_data <= rdata;
    end else if (state == DONE && buf_valid && buf_idx == idx) begin
      buf_data <= wdata;
    end
  end
  assign read_data = hit ? buf_data : rdata;
`else
  assign hit = 1'b0;
  assign hit_data = '0;
  assign read_data = rdata;
`endif
  assign SRAM_ADDR = {idx, state == ACC_HI};
  assign SRAM_CE_N = !acc;
  assign SRAM_UB_N = !acc;
  assign SRAM_LB_N = !acc;
  assign SRAM_WE_N = !(acc && op_wr);
  assign SRAM_OE_N = !(acc && !op_wr);
  assign SRAM_DQ = (acc && op_wr) ? (state == ACC_HI ? wdata[31:16] : wdata[15:0]) : 16'bz;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: randomized loads/stores against a word-level reference memory
// and a behavioural 16-bit SRAM attached to the DQ bus.
module tb_sram_controller;
  localparam int BASE = 1024;
  localparam int W = 2;
  localparam int LAT = 2 * W + 1;
`ifdef SRAM_READ_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rd_en = 1'b0;
  logic wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic ready;
  wire [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic we_n, oe_n, ce_n, ub_n, lb_n;
  logic probe = 1'b0;
  logic [15:0] mem [0:1023];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ref_mem [int];
  bit hv = 1'b0;
  int hidx = 0;

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  always #5 clk = ~clk;
  // Probe drives a known pattern so an idle bus reads it back unchanged.
  assign sram_dq = probe ? 16'h5A3C : (!ce_n && !oe_n && we_n) ? mem[sram_addr[9:0]] : 16'bz;
  always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr[9:0]] <= sram_dq;

  function automatic bit model_hit(bit is_read, int idx);
    return is_read && hv && hidx == idx;
  endfunction

  function automatic void model_commit(bit wr, int idx, logic [31:0] d);
    if (wr) ref_mem[idx] = d;
    else begin
      hv = HIT_EN;
      hidx = idx;
    end
  endfunction

  task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] d,
                           output int lat, output int ce, output int we, output int oe,
                           output logic [31:0] rdat);
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    address = addr;
    write_data = d;
    #1;
    lat = 0; ce = 0; we = 0; oe = 0;
    while (!ready && lat < 4 * LAT) begin
      @(negedge clk);
      lat++;
      ce += int'(!ce_n);
      we += int'(!we_n);
      oe += int'(!oe_n);
      if (lat == 1) begin
        rd_en = 1'($urandom);
        wr_en = 1'($urandom);
        address = $urandom;
        write_data = $urandom;
      end
    end
    rdat = read_data;
    if (lat == 0) @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    probe = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL reset_read_data: got %h expected 0", read_data); end
    n_cmp++; if ({we_n, oe_n, ce_n, ub_n, lb_n} !== 5'b11111) begin n_err++; $display("FAIL reset_strobes: got %b expected 11111", {we_n, oe_n, ce_n, ub_n, lb_n}); end
    n_cmp++; if (sram_dq !== 16'h5A3C) begin n_err++; $display("FAIL reset_bus_hiz: got %h expected 5a3c", sram_dq); end
    probe = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    int lat, ce, we, oe;
    logic [31:0] r;
    do_access(1'b1, 1'b0, 32'(BASE), 32'hDEADBEEF, lat, ce, we, oe, r);
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (we !== 2 * W || ce !== 2 * W || oe !== 0) begin n_err++; $display("FAIL wr_strobes: ce %0d we %0d oe %0d expected %0d %0d 0", ce, we, oe, 2 * W, 2 * W); end
    n_cmp++; if (mem[0] !== 16'hBEEF) begin n_err++; $display("FAIL wr_word0: got %h expected beef", mem[0]); end
    n_cmp++; if (mem[1] !== 16'hDEAD) begin n_err++; $display("FAIL wr_word1: got %h expected dead", mem[1]); end
    model_commit(1'b1, 0, 32'hDEADBEEF);
    @(negedge clk);
    probe = 1'b1;
    #1;
    n_cmp++; if (sram_dq !== 16'h5A3C) begin n_err++; $display("FAIL wr_bus_hiz: got %h expected 5a3c", sram_dq); end
    probe = 1'b0;
    do_access(1'b0, 1'b1, 32'(BASE), 32'h0, lat, ce, we, oe, r);
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (r !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h expected deadbeef", r); end
    n_cmp++; if (oe !== 2 * W || we !== 0) begin n_err++; $display("FAIL rd_strobes: oe %0d we %0d expected %0d 0", oe, we, 2 * W); end
    model_commit(1'b0, 0, 32'h0);
  endtask

  task automatic test_both_requests();
    int lat, ce, we, oe;
    logic [31:0] r;
    bit h;
    do_access(1'b1, 1'b1, 32'(BASE + 4), 32'h12345678, lat, ce, we, oe, r);
    n_cmp++; if (we !== 2 * W) begin n_err++; $display("FAIL both_is_write: we cycles %0d expected %0d", we, 2 * W); end
    n_cmp++; if ({mem[3], mem[2]} !== 32'h12345678) begin n_err++; $display("FAIL both_sram: got %h expected 12345678", {mem[3], mem[2]}); end
    model_commit(1'b1, 1, 32'h12345678);
    h = model_hit(1'b1, 1);
    do_access(1'b0, 1'b1, 32'(BASE + 4), 32'h0, lat, ce, we, oe, r);
    n_cmp++; if (r !== 32'h12345678) begin n_err++; $display("FAIL both_readback: got %h expected 12345678", r); end
    n_cmp++; if (lat !== (h ? 0 : LAT)) begin n_err++; $display("FAIL both_rd_latency: got %0d expected %0d", lat, h ? 0 : LAT); end
    model_commit(1'b0, 1, 32'h0);
  endtask

  task automatic test_random();
    int lat, ce, we, oe, idx;
    logic [31:0] r, d, a;
    bit wr, rd, h;
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 15);
      wr = !ref_mem.exists(idx) || $urandom_range(0, 2) == 0;
      rd = wr ? 1'($urandom) : 1'b1;
      d = $urandom;
      a = 32'(BASE + idx * 4 + $urandom_range(0, 3));
      h = model_hit(!wr, idx);
      do_access(wr, rd, a, d, lat, ce, we, oe, r);
      n_cmp++; if (lat !== (h ? 0 : LAT)) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, h ? 0 : LAT); end
      n_cmp++; if (ce !== (h ? 0 : 2 * W)) begin n_err++; $display("FAIL rand_ce[%0d]: got %0d expected %0d", i, ce, h ? 0 : 2 * W); end
      if (!wr) begin
        n_cmp++; if (r !== ref_mem[idx]) begin n_err++; $display("FAIL rand_read[%0d]: got %h expected %h", i, r, ref_mem[idx]); end
      end
      model_commit(wr, idx, d);
    end
  endtask

  task automatic test_reset_mid_access();
    int lat, ce, we, oe, idx;
    logic [31:0] r;
    idx = (hidx + 1) % 16;
    do_access(1'b1, 1'b0, 32'(BASE + idx * 4), 32'hA5A50F0F, lat, ce, we, oe, r);
    model_commit(1'b1, idx, 32'hA5A50F0F);
    @(negedge clk);
    rd_en = 1'b1;
    address = 32'(BASE + idx * 4);
    @(negedge clk);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (sram_addr[0] !== 1'b1 || ce_n !== 1'b0) begin n_err++; $display("FAIL mid_in_hi_phase: addr0 %b ce_n %b expected 1 0", sram_addr[0], ce_n); end
    rst = 1'b0;
    probe = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b1 || read_data !== 32'h0) begin n_err++; $display("FAIL mid_reset_out: ready %b data %h expected 1 0", ready, read_data); end
    n_cmp++; if ({we_n, oe_n, ce_n, ub_n, lb_n} !== 5'b11111) begin n_err++; $display("FAIL mid_reset_strobes: got %b expected 11111", {we_n, oe_n, ce_n, ub_n, lb_n}); end
    n_cmp++; if (sram_dq !== 16'h5A3C) begin n_err++; $display("FAIL mid_reset_bus: got %h expected 5a3c", sram_dq); end
    probe = 1'b0;
    hv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_access(1'b0, 1'b1, 32'(BASE + idx * 4), 32'h0, lat, ce, we, oe, r);
    n_cmp++; if (lat !== LAT || r !== 32'hA5A50F0F) begin n_err++; $display("FAIL mid_after_read: lat %0d data %h expected %0d a5a50f0f", lat, r, LAT); end
    model_commit(1'b0, idx, 32'h0);
  endtask

  task automatic test_back_to_back();
    int lat, ce, we, oe;
    logic [31:0] r;
    bit h;
    for (int k = 0; k < 2; k++) begin
      h = model_hit(1'b1, 0);
      do_access(1'b0, 1'b1, 32'(BASE), 32'h0, lat, ce, we, oe, r);
      n_cmp++; if (lat !== (h ? 0 : LAT) || ce !== (h ? 0 : 2 * W)) begin n_err++; $display("FAIL b2b_read%0d: lat %0d ce %0d expected %0d %0d", k, lat, ce, h ? 0 : LAT, h ? 0 : 2 * W); end
      n_cmp++; if (r !== ref_mem[0]) begin n_err++; $display("FAIL b2b_data%0d: got %h expected %h", k, r, ref_mem[0]); end
      model_commit(1'b0, 0, 32'h0);
    end
    do_access(1'b1, 1'b0, 32'(BASE), 32'h0000FFFF, lat, ce, we, oe, r);
    model_commit(1'b1, 0, 32'h0000FFFF);
    h = model_hit(1'b1, 0);
    do_access(1'b0, 1'b1, 32'(BASE), 32'h0, lat, ce, we, oe, r);
    n_cmp++; if (r !== 32'h0000FFFF || lat !== (h ? 0 : LAT)) begin n_err++; $display("FAIL b2b_after_write: data %h lat %0d expected 0000ffff %0d", r, lat, h ? 0 : LAT); end
    model_commit(1'b0, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_both_requests();
    test_random();
    test_reset_mid_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 1024: byte address mapped to SRAM word 0.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, minimum 1: clock cycles per 16-bit half access.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports rd_en and wr_en, both input, 1 bit: memory-stage read and write requests.
REQ-006 SHALL have port address, input, 32 bits: byte address (ALU result).
REQ-007 SHALL have port write_data, input, 32 bits: store data (val_Rm).
REQ-008 SHALL have port read_data, output, 32 bits: load data.
REQ-009 SHALL have port ready, output, 1 bit: high means the pipeline may advance; low means freeze.
REQ-010 SHALL have port SRAM_DQ, inout, 16 bits: SRAM data bus.
REQ-011 SHALL have port SRAM_ADDR, output, 18 bits: SRAM word address.
REQ-012 SHALL have ports SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N and SRAM_LB_N, all output, 1 bit, active-low strobes.

Function
REQ-013 SHALL implement an FSM with states IDLE, ACC_LO, ACC_HI and DONE.
REQ-014 In IDLE, on rd_en or wr_en: latch op, address and write_data, then go to ACC_LO; wr_en SHALL win if both are high.
REQ-015 Word index SHALL be (address - BASE_ADDR) >> 2, truncated to 17 bits; address[1:0] SHALL be ignored.
REQ-016 SRAM_ADDR SHALL be {index, 0} in ACC_LO and {index, 1} in ACC_HI.
REQ-017 ACC_LO and ACC_HI SHALL each last exactly WAIT_CYCLES cycles, timed by a down-counter, then advance (ACC_LO to ACC_HI, ACC_HI to DONE).
REQ-018 DONE SHALL last 1 cycle, then return to IDLE.
REQ-019 ready SHALL be combinational: 1 in IDLE with no request, 1 in DONE, and 0 otherwise, including the IDLE cycle in which a request appears.
REQ-020 For a miss, ready SHALL rise exactly 2*WAIT_CYCLES+1 cycles after the request cycle (5 at default).
REQ-021 Read: SRAM_DQ SHALL be captured on the last cycle of ACC_LO into read_data[15:0] and on the last cycle of ACC_HI into read_data[31:16].
REQ-022 read_data SHALL be valid in DONE and SHALL hold until the next read completes.
REQ-023 Write: SRAM_DQ SHALL be driven with write_data[15:0] in ACC_LO and write_data[31:16] in ACC_HI, and SHALL be high-Z in all other states and for reads.
REQ-024 Strobes: CE_N, UB_N and LB_N SHALL be low in ACC states; WE_N SHALL be low in ACC states for writes; OE_N SHALL be low in ACC states for reads; all strobes SHALL be high otherwise.
REQ-025 Request changes during ACC states or DONE SHALL be ignored; the latched values SHALL be used.
REQ-026 A request still held in the DONE cycle SHALL NOT be restarted; the request present in the following IDLE cycle SHALL be treated as new.

Reset
REQ-027 On rst low (asynchronous): state SHALL be IDLE, counter 0, read_data 0 and all strobes high.
REQ-028 On rst low: SRAM_DQ SHALL be high-Z and the hit buffer SHALL be invalidated.
REQ-029 Reset asserted mid-access SHALL abort the access with no completion; the SRAM contents of a partial write are undefined.

Configuration
REQ-030 Macro SRAM_READ_HIT_EN SHALL, when defined, add a one-entry buffer holding {valid, index, data} from the last completed read.
REQ-031 With SRAM_READ_HIT_EN defined, a read in IDLE whose index matches a valid entry SHALL give ready=1 and read_data=buffered data in the same cycle, with no SRAM access and the FSM staying in IDLE.
REQ-032 With SRAM_READ_HIT_EN defined, a completed write to the buffered index SHALL update the buffered data.
REQ-033 Without SRAM_READ_HIT_EN, every access SHALL take the full FSM path and no buffer logic SHALL exist.

Structure
REQ-034 The shared defines file SHALL hold WORD_WIDTH, SRAM_DATA_WIDTH (16), SRAM_ADDR_WIDTH (18) and the FSM state encodings.
REQ-035 One sub-module, sram_wait_counter (load WAIT_CYCLES, decrement, done flag), SHALL be used for both ACC states.

Verification
REQ-036 Write 0xDEADBEEF to 1024, WAIT_CYCLES=2: ready low for 5 cycles; SRAM word 0 = 0xBEEF, word 1 = 0xDEAD; DQ high-Z afterwards.
REQ-037 Read 1024 after REQ-036: read_data = 0xDEADBEEF in DONE, 5 cycles after the request.
REQ-038 rd_en and wr_en both high at 1028 with data 0x12345678: a write is performed; a later read of 1028 returns 0x12345678.
REQ-039 Assert rst low during ACC_HI of a read: state IDLE, ready 1 and read_data 0 immediately; strobes high.
REQ-040 With SRAM_READ_HIT_EN, two back-to-back reads of 1024: the second has ready=1 in its request cycle and CE_N stays high.
REQ-041 With SRAM_READ_HIT_EN, read 1024, write 0x0000FFFF to 1024, read 1024: returns 0x0000FFFF via a hit.
